// File: rtl/ff_pkg.sv
// Shared definitions for the multimode flip-flop bank: mode and SR-policy
// encodings plus the single-channel next-state function.
package ff_pkg;

   typedef enum logic [1:0] {
      MODE_SR = 2'b00,
      MODE_JK = 2'b01,
      MODE_D  = 2'b10,
      MODE_T  = 2'b11
   } ff_mode_e;

   localparam logic [1:0] POL_HOLD = 2'd0;
   localparam logic [1:0] POL_SET  = 2'd1;
   localparam logic [1:0] POL_RST  = 2'd2;
   localparam logic [1:0] POL_TOG  = 2'd3;

   // Next value of one channel given its mode, the S=R=1 policy and its inputs.
   function automatic logic ff_next(input ff_mode_e mode, input logic [1:0] policy,
                                    input logic a, input logic b, input logic q);
      logic nxt;
      nxt = q;
      case (mode)
         MODE_SR: begin
            case ({a, b})
               2'b10:   nxt = 1'b1;
               2'b01:   nxt = 1'b0;
               2'b11: begin
                  case (policy)
                     POL_SET: nxt = 1'b1;
                     POL_RST: nxt = 1'b0;
                     POL_TOG: nxt = ~q;
                     default: nxt = q;
                  endcase
               end
               default: nxt = q;
            endcase
         end
         MODE_JK: begin
            case ({a, b})
               2'b10:   nxt = 1'b1;
               2'b01:   nxt = 1'b0;
               2'b11:   nxt = ~q;
               default: nxt = q;
            endcase
         end
         MODE_D:  nxt = a;
         MODE_T:  nxt = a ? ~q : q;
         default: nxt = q;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/ff_cell.sv
// One flip-flop channel: registered state plus mode-dependent next-state logic.
module ff_cell
   import ff_pkg::*;
#(
   parameter logic [1:0] POLICY    = POL_HOLD,
   parameter logic       RESET_BIT = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic       a,
   input  logic       b,
   output logic       q
);

   logic q_q;
   logic q_d;

   // Next state: evaluate the selected flop behaviour, or hold when disabled.
   always_comb begin
      q_d = q_q;
      if (en) begin
         q_d = ff_next(ff_mode_e'(mode), POLICY, a, b, q_q);
      end else begin
         q_d = q_q;
      end
   end

   // Channel state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= RESET_BIT;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/multimode_ff_bank.sv
// Bank of WIDTH runtime-selectable SR/JK/D/T flip-flops with sticky per-channel
// SR-conflict flags and a saturating count of conflict cycles.
module multimode_ff_bank
   import ff_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter int               SR_POLICY = 0,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
   parameter int               CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             clr_conflict,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n,
   output logic [WIDTH-1:0] conflict_flags,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] new_c_s;
   logic [WIDTH-1:0] flags_q;
   logic [WIDTH-1:0] flags_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_base_s;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      ff_cell #(
         .POLICY    (SR_POLICY[1:0]),
         .RESET_BIT (RESET_VAL[i])
      ) u_cell (
         .clk  (clk),
         .rst  (rst),
         .en   (en),
         .mode (mode),
         .a    (a[i]),
         .b    (b[i]),
         .q    (q[i])
      );
   end

   assign q_n = ~q;

   // Conflict detection and flag/counter next state; a clear never hides a same-cycle conflict.
   always_comb begin
      new_c_s    = {WIDTH{en & (mode == MODE_SR)}} & a & b;
      flags_d    = (clr_conflict ? {WIDTH{1'b0}} : flags_q) | new_c_s;
      cnt_base_s = clr_conflict ? {CNT_W{1'b0}} : cnt_q;
      if ((|new_c_s) && (cnt_base_s != CNT_MAX)) begin
         cnt_d = cnt_base_s + CNT_ONE;
      end else begin
         cnt_d = cnt_base_s;
      end
   end

   // Conflict flag and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= {WIDTH{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
      end else begin
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
      end
   end

   assign conflict_flags = flags_q;
   assign conflict_cnt   = cnt_q;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Bench for multimode_ff_bank (WIDTH=8, toggle SR policy, RESET_VAL=3C, CNT_W=2):
// vectors are driven on negedge, expectations queued, and checked after posedge.
module tb_multimode_ff_bank;

   localparam logic [1:0] M_SR = 2'b00;
   localparam logic [1:0] M_JK = 2'b01;
   localparam logic [1:0] M_D  = 2'b10;
   localparam logic [1:0] M_T  = 2'b11;

   typedef struct {
      int         id;
      logic       rst;
      logic       en;
      logic [1:0] mode;
      logic [7:0] a;
      logic [7:0] b;
      logic       clr;
      logic [7:0] exp_q;
      logic [7:0] exp_f;
      logic [1:0] exp_c;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic       clr_conflict = 1'b0;
   logic [7:0] q;
   logic [7:0] q_n;
   logic [7:0] conflict_flags;
   logic [1:0] conflict_cnt;

   int checks = 0;
   int errors = 0;
   vec_t sb[$];
   vec_t tbl[18];

   multimode_ff_bank #(
      .WIDTH     (8),
      .SR_POLICY (3),
      .RESET_VAL (8'h3C),
      .CNT_W     (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .mode           (mode),
      .a              (a),
      .b              (b),
      .clr_conflict   (clr_conflict),
      .q              (q),
      .q_n            (q_n),
      .conflict_flags (conflict_flags),
      .conflict_cnt   (conflict_cnt)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(int id, logic r, logic e, logic [1:0] m, logic [7:0] va,
                               logic [7:0] vb, logic c, logic [7:0] eq, logic [7:0] ef,
                               logic [1:0] ec);
      vec_t v;
      v.id = id; v.rst = r; v.en = e; v.mode = m; v.a = va; v.b = vb; v.clr = c;
      v.exp_q = eq; v.exp_f = ef; v.exp_c = ec;
      return v;
   endfunction

   task automatic step(input vec_t v);
      @(negedge clk);
      rst = v.rst; en = v.en; mode = v.mode; a = v.a; b = v.b; clr_conflict = v.clr;
      sb.push_back(v);
   endtask

   // Scoreboard: compare the oldest queued expectation just after each edge.
   initial begin
      vec_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (q !== e.exp_q) begin
               errors++;
               $display("FAIL q step %0d: got %h want %h", e.id, q, e.exp_q);
            end
            checks++;
            if (q_n !== ~e.exp_q) begin
               errors++;
               $display("FAIL q_n step %0d: got %h want %h", e.id, q_n, ~e.exp_q);
            end
            checks++;
            if (conflict_flags !== e.exp_f) begin
               errors++;
               $display("FAIL flags step %0d: got %h want %h", e.id, conflict_flags, e.exp_f);
            end
            checks++;
            if (conflict_cnt !== e.exp_c) begin
               errors++;
               $display("FAIL cnt step %0d: got %0d want %0d", e.id, conflict_cnt, e.exp_c);
            end
         end
      end
   end

   initial begin
      //            id  rst   en    mode  a      b      clr   q      flags  cnt
      tbl[0]  = mk( 0, 1'b1, 1'b1, M_SR, 8'hFF, 8'hFF, 1'b0, 8'h3C, 8'h00, 2'd0);
      tbl[1]  = mk( 1, 1'b0, 1'b1, M_SR, 8'h01, 8'h00, 1'b0, 8'h3D, 8'h00, 2'd0);
      tbl[2]  = mk( 2, 1'b0, 1'b1, M_SR, 8'h00, 8'h00, 1'b0, 8'h3D, 8'h00, 2'd0);
      tbl[3]  = mk( 3, 1'b0, 1'b1, M_SR, 8'h00, 8'h01, 1'b0, 8'h3C, 8'h00, 2'd0);
      tbl[4]  = mk( 4, 1'b0, 1'b1, M_SR, 8'h00, 8'h00, 1'b0, 8'h3C, 8'h00, 2'd0);
      tbl[5]  = mk( 5, 1'b0, 1'b1, M_SR, 8'h01, 8'h01, 1'b0, 8'h3D, 8'h01, 2'd1);
      tbl[6]  = mk( 6, 1'b0, 1'b1, M_D,  8'h00, 8'hFF, 1'b0, 8'h00, 8'h01, 2'd1);
      tbl[7]  = mk( 7, 1'b0, 1'b1, M_JK, 8'hFF, 8'hFF, 1'b0, 8'hFF, 8'h01, 2'd1);
      tbl[8]  = mk( 8, 1'b0, 1'b1, M_JK, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h01, 2'd1);
      tbl[9]  = mk( 9, 1'b0, 1'b1, M_JK, 8'hFF, 8'hFF, 1'b0, 8'hFF, 8'h01, 2'd1);
      tbl[10] = mk(10, 1'b0, 1'b1, M_JK, 8'hF0, 8'h0F, 1'b0, 8'hF0, 8'h01, 2'd1);
      tbl[11] = mk(11, 1'b0, 1'b1, M_T,  8'h0F, 8'hFF, 1'b0, 8'hFF, 8'h01, 2'd1);
      tbl[12] = mk(12, 1'b0, 1'b1, M_T,  8'h0F, 8'h00, 1'b0, 8'hF0, 8'h01, 2'd1);
      tbl[13] = mk(13, 1'b0, 1'b0, M_D,  8'hA5, 8'h00, 1'b0, 8'hF0, 8'h01, 2'd1);
      tbl[14] = mk(14, 1'b0, 1'b0, M_SR, 8'hFF, 8'hFF, 1'b0, 8'hF0, 8'h01, 2'd1);
      tbl[15] = mk(15, 1'b0, 1'b1, M_D,  8'hA5, 8'h00, 1'b0, 8'hA5, 8'h01, 2'd1);
      tbl[16] = mk(16, 1'b0, 1'b0, M_D,  8'h00, 8'h00, 1'b1, 8'hA5, 8'h00, 2'd0);
      tbl[17] = mk(17, 1'b0, 1'b1, M_SR, 8'hF0, 8'h0F, 1'b0, 8'hF0, 8'h00, 2'd0);

      for (int i = 0; i < 18; i++) begin
         step(tbl[i]);
      end

      // Counter saturation with toggle policy on channel 0, then clear with a same-cycle conflict.
      step(mk(20, 1'b0, 1'b1, M_SR, 8'h01, 8'h01, 1'b0, 8'hF1, 8'h01, 2'd1));
      step(mk(21, 1'b0, 1'b1, M_SR, 8'h01, 8'h01, 1'b0, 8'hF0, 8'h01, 2'd2));
      step(mk(22, 1'b0, 1'b1, M_SR, 8'h01, 8'h01, 1'b0, 8'hF1, 8'h01, 2'd3));
      step(mk(23, 1'b0, 1'b1, M_SR, 8'h01, 8'h01, 1'b0, 8'hF0, 8'h01, 2'd3));
      step(mk(24, 1'b0, 1'b1, M_SR, 8'h01, 8'h01, 1'b0, 8'hF1, 8'h01, 2'd3));
      step(mk(25, 1'b0, 1'b1, M_SR, 8'h01, 8'h01, 1'b1, 8'hF0, 8'h01, 2'd1));
      step(mk(26, 1'b0, 1'b1, M_SR, 8'h00, 8'h00, 1'b1, 8'hF0, 8'h00, 2'd0));

      // Mid-run reset inside a toggle sequence, with a pending conflict flag.
      step(mk(30, 1'b0, 1'b1, M_T,  8'hFF, 8'h00, 1'b0, 8'h0F, 8'h00, 2'd0));
      step(mk(31, 1'b0, 1'b1, M_SR, 8'h80, 8'h80, 1'b0, 8'h8F, 8'h80, 2'd1));
      step(mk(32, 1'b1, 1'b1, M_SR, 8'hFF, 8'hFF, 1'b1, 8'h3C, 8'h00, 2'd0));
      step(mk(33, 1'b0, 1'b1, M_T,  8'hFF, 8'h00, 1'b0, 8'hC3, 8'h00, 2'd0));
      step(mk(34, 1'b0, 1'b1, M_T,  8'hFF, 8'h00, 1'b0, 8'h3C, 8'h00, 2'd0));

      for (int i = 0; i < 10 && sb.size() != 0; i++) begin
         @(posedge clk);
      end
      #2;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
